// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature-code accumulator.
package tmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } accum_state_t;

    localparam int TMP_OSR_LOG2_DEF = 8;

endpackage

// File: rtl/tmp_code_accum_if.sv
// Result handshake between the accumulator and the readout/bus.
interface tmp_code_accum_if #(
    parameter int CODE_W = 9
);

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;

    modport master (
        output code,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code,
        input  code_valid,
        output code_ready
    );

endinterface

// File: rtl/tmp_toggle_det.sv
// Level-change detector: arm loads the baseline without reporting an event,
// track keeps following the input and flags every level change.
module tmp_toggle_det (
    input  logic clk,
    input  logic reset_n,
    input  logic arm,
    input  logic track,
    input  logic din,
    output logic toggle
);

    logic prev;

    // Previous-level register, refreshed while arming or tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b0;
        end else if (arm || track) begin
            prev <= din;
        end
    end

    assign toggle = track && (din != prev);

endmodule

// File: rtl/tmp_code_accum.sv
// Counts src/snk toggle events over 2**OSR_LOG2-event windows and hands the
// per-window src count out as the temperature code.
module tmp_code_accum
    import tmp_pkg::*;
#(
    parameter int OSR_LOG2 = TMP_OSR_LOG2_DEF,
    parameter int CODE_W   = OSR_LOG2 + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                src_n,
    input  logic                snk,
    tmp_code_accum_if.master    out,
    output logic                busy,
    output logic                overrun,
    output logic                proto_err
);

    localparam logic [CODE_W-1:0] LAST_EVT = CODE_W'((1 << OSR_LOG2) - 1);

    accum_state_t      state;
    logic [CODE_W-1:0] evt_cnt;
    logic [CODE_W-1:0] src_cnt;
    logic [CODE_W-1:0] final_code;
    logic [CODE_W-1:0] code_q;
    logic              code_valid_q;
    logic              ts;
    logic              tk;
    logic              win_end;

    tmp_toggle_det u_src_det (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (state == ARM),
        .track   (state == COUNT),
        .din     (src_n),
        .toggle  (ts)
    );

    tmp_toggle_det u_snk_det (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (state == ARM),
        .track   (state == COUNT),
        .din     (snk),
        .toggle  (tk)
    );

    // Window-completion decode and the result it would deliver.
    always_comb begin
        final_code = src_cnt + CODE_W'(ts);
        win_end    = 1'b0;
        if (state == COUNT && en && (ts ^ tk) && evt_cnt == LAST_EVT) begin
            win_end = 1'b1;
        end
    end

    // Phase FSM with event counters, registered busy and sticky protocol error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            evt_cnt   <= '0;
            src_cnt   <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (en) begin
                        state <= ARM;
                    end else begin
                        proto_err <= 1'b0;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        evt_cnt <= '0;
                        src_cnt <= '0;
                        state   <= COUNT;
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ts && tk) begin
                        proto_err <= 1'b1;
                    end else if (ts ^ tk) begin
                        // Window wraps in place: next window starts on the following event.
                        if (win_end) begin
                            evt_cnt <= '0;
                            src_cnt <= '0;
                        end else begin
                            evt_cnt <= evt_cnt + CODE_W'(1);
                            src_cnt <= src_cnt + CODE_W'(ts);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register, handshake and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q       <= '0;
            code_valid_q <= 1'b0;
            overrun      <= 1'b0;
        end else if (win_end) begin
            if (!code_valid_q || out.code_ready) begin
                code_q       <= final_code;
                code_valid_q <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else begin
            if (code_valid_q && out.code_ready) begin
                code_valid_q <= 1'b0;
            end
            if (state == IDLE && !en) begin
                overrun <= 1'b0;
            end
        end
    end

    assign out.code       = code_q;
    assign out.code_valid = code_valid_q;

endmodule

// File: tb/tb_tmp_code_accum.sv
// Testbench for tmp_code_accum with OSR_LOG2=3 (8-event windows).
module tb_tmp_code_accum;

    localparam int OSR_LOG2 = 3;
    localparam int CODE_W   = OSR_LOG2 + 1;
    localparam int WIN      = 1 << OSR_LOG2;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic src_n;
    logic snk;
    logic ready;
    logic busy;
    logic overrun;
    logic proto_err;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    tmp_code_accum_if #(.CODE_W(CODE_W)) bus ();

    assign bus.code_ready = ready;

    tmp_code_accum #(
        .OSR_LOG2 (OSR_LOG2),
        .CODE_W   (CODE_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .src_n     (src_n),
        .snk       (snk),
        .out       (bus),
        .busy      (busy),
        .overrun   (overrun),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tog_src(input int n);
        for (int i = 0; i < n; i++) begin
            src_n = ~src_n;
            cyc();
        end
    endtask

    task automatic tog_snk(input int n);
        for (int i = 0; i < n; i++) begin
            snk = ~snk;
            cyc();
        end
    endtask

    // Reference model: phases, event queue per window, result register.
    int m_phase;
    logic m_ps, m_pk;
    bit win_q[$];
    int m_code;
    bit m_valid, m_ovr, m_perr, m_busy;

    always @(posedge clk or negedge reset_n) begin
        bit done;
        int res;
        bit ts, tk;
        if (!reset_n) begin
            m_phase = 0;
            m_ps = 1'b0;
            m_pk = 1'b0;
            win_q.delete();
            m_code = 0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_perr = 1'b0;
            m_busy = 1'b0;
        end else begin
            done = 1'b0;
            res = 0;
            if (m_phase == 0) begin
                if (en) m_phase = 1;
                else begin
                    m_ovr = 1'b0;
                    m_perr = 1'b0;
                end
            end else if (!en) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                m_ps = src_n;
                m_pk = snk;
                win_q.delete();
                m_phase = 2;
            end else begin
                ts = (src_n != m_ps);
                tk = (snk != m_pk);
                m_ps = src_n;
                m_pk = snk;
                if (ts && tk) m_perr = 1'b1;
                else if (ts || tk) begin
                    win_q.push_back(ts);
                    if (win_q.size() == WIN) begin
                        foreach (win_q[j]) res += int'(win_q[j]);
                        win_q.delete();
                        done = 1'b1;
                    end
                end
            end
            m_busy = (m_phase == 2);
            if (done) begin
                if (!m_valid || ready) begin
                    m_code = res;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_on && reset_n) begin
            chk("model_code", bus.code, m_code);
            chk("model_valid", bus.code_valid, m_valid);
            chk("model_busy", busy, m_busy);
            chk("model_overrun", overrun, m_ovr);
            chk("model_proto_err", proto_err, m_perr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic en;
        logic s;
        logic k;
        logic r;
        int   code;
        int   valid;
        int   busy;
    } vec_t;

    vec_t vt[12];

    initial begin
        // Basic window: 5 src + 3 snk events, accepted immediately.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5, 1, 1};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 1};
        vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 5, 0, 0};

        reset_n = 1'b0;
        en = 1'b0;
        src_n = 1'b0;
        snk = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_code", bus.code, 0);
        chk("reset_valid", bus.code_valid, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        model_on = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            en = vt[i].en;
            src_n = vt[i].s;
            snk = vt[i].k;
            ready = vt[i].r;
            cyc();
            chk("basic_code", bus.code, vt[i].code);
            chk("basic_valid", bus.code_valid, vt[i].valid);
            chk("basic_busy", busy, vt[i].busy);
        end

        // Baseline: src_n already high before en rises; snk-only then src-only windows.
        src_n = 1'b1;
        cyc();
        en = 1'b1;
        cyc();
        cyc();
        chk("base_busy", busy, 1);
        tog_snk(WIN);
        chk("base_snk_code", bus.code, 0);
        chk("base_snk_valid", bus.code_valid, 1);
        tog_src(WIN - 1);
        chk("base_src_pending", bus.code_valid, 0);
        tog_src(1);
        chk("base_src_code", bus.code, 8);
        chk("base_src_valid", bus.code_valid, 1);

        // Back-to-back windows under backpressure.
        en = 1'b0;
        cyc();
        cyc();
        en = 1'b1;
        cyc();
        cyc();
        ready = 1'b0;
        tog_src(2);
        tog_snk(6);
        chk("bp_first_code", bus.code, 2);
        chk("bp_first_valid", bus.code_valid, 1);
        tog_src(6);
        tog_snk(2);
        chk("bp_held_code", bus.code, 2);
        chk("bp_overrun", overrun, 1);
        ready = 1'b1;
        cyc();
        chk("bp_accept_valid", bus.code_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);
        ready = 1'b0;
        en = 1'b0;
        cyc();
        chk("bp_overrun_leave", overrun, 1);
        chk("bp_idle_busy", busy, 0);
        cyc();
        chk("bp_overrun_clear", overrun, 0);

        // Accept on the same edge that completes the next window.
        en = 1'b1;
        cyc();
        cyc();
        tog_src(3);
        tog_snk(5);
        chk("edge_first_code", bus.code, 3);
        tog_src(7);
        ready = 1'b1;
        tog_snk(1);
        chk("edge_code", bus.code, 7);
        chk("edge_valid", bus.code_valid, 1);
        chk("edge_overrun", overrun, 0);
        cyc();
        chk("edge_drain", bus.code_valid, 0);

        // Simultaneous toggle, then abort a partial window.
        src_n = ~src_n;
        snk = ~snk;
        cyc();
        chk("err_proto", proto_err, 1);
        tog_src(4);
        en = 1'b0;
        cyc();
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.code_valid, 0);
        cyc();
        chk("abort_proto_clear", proto_err, 0);
        en = 1'b1;
        ready = 1'b0;
        cyc();
        cyc();
        tog_src(1);
        tog_snk(3);
        chk("fresh_half", bus.code_valid, 0);
        tog_snk(4);
        chk("fresh_code", bus.code, 1);
        chk("fresh_valid", bus.code_valid, 1);

        // Asynchronous reset mid-window with a result held.
        tog_src(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_code", bus.code, 0);
        chk("areset_valid", bus.code_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_overrun", overrun, 0);
        chk("areset_proto", proto_err, 0);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("areset_idle", busy, 0);
        en = 1'b1;
        cyc();
        cyc();
        chk("areset_rearm", busy, 1);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            int e;
            en = ($urandom_range(0, 99) >= 2);
            ready = ($urandom_range(0, 2) != 0);
            e = $urandom_range(0, 15);
            if (e <= 5) src_n = ~src_n;
            else if (e <= 11) snk = ~snk;
            else if (e == 12) begin
                src_n = ~src_n;
                snk = ~snk;
            end
            cyc();
        end

        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
